image_ram_loader: RTL and testbench

IMAGE_RAM_LOADER -- requirements
Module: image_ram_loader

---
 rtl/image_ram_loader.sv | 143 ++++++++++++++
 tb/tb_image_ram_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_ram_loader.sv
// Image RAM loader: packs a byte stream into wide image words and writes
// each word to port A of a block RAM, one address per image.
// Pixel 0 of each image lands in the least significant byte of the word.
module image_ram_loader #(
    parameter int IMG_SIZE   = 256,
    parameter int NUM_IMAGES = 512,
    parameter int ADDR_W     = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    output logic                    s_ready,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*IMG_SIZE-1:0]   wr_data,
    output logic [ADDR_W:0]         img_count,
    output logic                    load_done
);

    localparam int CNT_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(IMG_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_IMAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic [8*IMG_SIZE-1:0]   r_pack;
    logic                    r_s_ready;
    logic                    r_wr_en;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [ADDR_W:0]         r_img_count;
    logic                    r_load_done;

    logic                    w_accept;
    logic                    w_last_byte;

    // s_ready is registered and only ever high in FILL, so it alone gates acceptance
    assign w_accept    = s_valid && r_s_ready;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // Control FSM: byte counting, write pulse, address/count bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_byte_cnt  <= '0;
            r_s_ready   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_img_count <= '0;
            r_load_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= FILL;
                        r_s_ready   <= 1'b1;
                        r_byte_cnt  <= '0;
                        r_wr_addr   <= '0;
                        r_img_count <= '0;
                        r_load_done <= 1'b0;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        if (w_last_byte) begin
                            // Word complete: stop the stream and pulse the write next cycle
                            r_state    <= WRITE;
                            r_s_ready  <= 1'b0;
                            r_wr_en    <= 1'b1;
                            r_byte_cnt <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    r_wr_en     <= 1'b0;
                    r_img_count <= r_img_count + (ADDR_W+1)'(1);
                    if (r_wr_addr == LAST_ADDR) begin
                        // Final image written: hold the address and report completion
                        r_state     <= DONE;
                        r_s_ready   <= 1'b0;
                        r_load_done <= 1'b1;
                    end else begin
                        r_state   <= FILL;
                        r_s_ready <= 1'b1;
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        r_state     <= FILL;
                        r_s_ready   <= 1'b1;
                        r_byte_cnt  <= '0;
                        r_wr_addr   <= '0;
                        r_img_count <= '0;
                        r_load_done <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_s_ready <= 1'b0;
                    r_wr_en   <= 1'b0;
                end
            endcase
        end
    end

    // Pack buffer: one byte lane per pixel, loaded when the byte counter selects it.
    // Lanes are never cleared between images because every lane is rewritten first.
    genvar gi;
    generate
        for (gi = 0; gi < IMG_SIZE; gi++) begin : g_lane
            // Capture the accepted pixel into its lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pack[8*gi +: 8] <= 8'h00;
                end else if (w_accept && (r_byte_cnt == CNT_W'(gi))) begin
                    r_pack[8*gi +: 8] <= s_data;
                end
            end
        end
    endgenerate

    // A reset raised during the write cycle must suppress the RAM write at the
    // coming edge, so the registered enable is masked by rst.
    assign wr_en     = r_wr_en && !rst;
    assign s_ready   = r_s_ready;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_pack;
    assign img_count = r_img_count;
    assign load_done = r_load_done;

endmodule

// File: tb/tb_image_ram_loader.sv
// Bench for image_ram_loader: a small instance (4-byte images, 2 images) for
// the FSM sequences and a default-parameter instance for the 256-byte word.
// Expected RAM writes are queued by the stimulus and popped by monitors.
module tb_image_ram_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Small instance
    logic        start   = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_ready;
    logic        wr_en;
    logic [0:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  img_count;
    logic        load_done;

    // Default-parameter instance
    logic          b_start   = 1'b0;
    logic          b_valid   = 1'b0;
    logic [7:0]    b_data    = 8'h00;
    logic          b_ready;
    logic          b_wr_en;
    logic [8:0]    b_wr_addr;
    logic [2047:0] b_wr_data;
    logic [9:0]    b_img_count;
    logic          b_load_done;

    image_ram_loader #(.IMG_SIZE(4), .NUM_IMAGES(2), .ADDR_W(1)) u_small (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .img_count(img_count), .load_done(load_done)
    );

    image_ram_loader u_big (
        .clk(clk), .rst(rst), .start(b_start), .s_valid(b_valid), .s_data(b_data),
        .s_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .img_count(b_img_count), .load_done(b_load_done)
    );

    int checks = 0;
    int errors = 0;
    int big_writes = 0;

    logic [32:0]   exp_q[$];   // {addr, data} for the small instance
    logic [2047:0] big_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_timeout", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_big(input logic [7:0] b);
        int n = 0;
        b_valid = 1'b1;
        b_data  = b;
        while (!b_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("big_send_timeout", 64'(b_ready), 64'd1);
        tick();
        b_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_img_count"}, 64'(img_count), 64'd0);
        chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    endtask

    // Small-instance monitor: every write pulse must match the next queued entry
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", wr_addr, wr_data);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(wr_addr), 64'(e[32]));
                chk("write_data", 64'(wr_data), 64'(e[31:0]));
                $display("write addr=%0d data=0x%08h", wr_addr, wr_data);
            end
        end
    end

    // Big-instance monitor
    always @(negedge clk) begin
        if (b_wr_en === 1'b1) begin
            big_writes++;
            if (big_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL big_unexpected_write: addr %0d, none expected", b_wr_addr);
            end else begin
                logic [2047:0] e;
                int bad;
                e = big_q.pop_front();
                chk("big_write_addr", 64'(b_wr_addr), 64'd0);
                bad = -1;
                for (int i = 255; i >= 0; i--)
                    if (b_wr_data[8*i +: 8] !== e[8*i +: 8]) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL big_write_data: byte %0d got 0x%02h expected 0x%02h",
                             bad, b_wr_data[8*bad +: 8], e[8*bad +: 8]);
                end
                $display("big write addr=%0d byte0=0x%02h byte255=0x%02h",
                         b_wr_addr, b_wr_data[7:0], b_wr_data[2047:2040]);
            end
        end
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2047:0] big_exp;

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) chk_reset_vals("idle");
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_s_ready", 64'(s_ready), 64'd0);
            chk("idle_wr_en", 64'(wr_en), 64'd0);
        end

        // First image, back-to-back bytes
        pulse_start();
        chk("fill_s_ready", 64'(s_ready), 64'd1);
        chk("fill_img_count", 64'(img_count), 64'd0);
        exp_q.push_back({1'b0, 32'h44332211});
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("img0_latency_wr_en", 64'(wr_en), 64'd1);
        chk("img0_write_s_ready", 64'(s_ready), 64'd0);
        tick();
        chk("img0_count_after", 64'(img_count), 64'd1);
        chk("img0_wr_en_after", 64'(wr_en), 64'd0);
        chk("img1_s_ready", 64'(s_ready), 64'd1);

        // Second image with 3-cycle gaps; it is the last one
        exp_q.push_back({1'b1, 32'hA3A2A1A0});
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick();
            chk("gap_wr_en", 64'(wr_en), 64'd0);
            send(8'hA0 + 8'(i));
        end
        chk("img1_latency_wr_en", 64'(wr_en), 64'd1);
        chk("img1_wr_addr", 64'(wr_addr), 64'd1);
        tick();
        chk("done_load_done", 64'(load_done), 64'd1);
        chk("done_img_count", 64'(img_count), 64'd2);
        chk("done_s_ready", 64'(s_ready), 64'd0);
        chk("done_wr_addr_hold", 64'(wr_addr), 64'd1);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("done_no_write", 64'(wr_en), 64'd0);
            chk("done_stays", 64'(load_done), 64'd1);
        end
        s_valid = 1'b0;

        // Restart from DONE; a start in FILL must not disturb the fill
        pulse_start();
        chk("restart_load_done", 64'(load_done), 64'd0);
        chk("restart_img_count", 64'(img_count), 64'd0);
        chk("restart_wr_addr", 64'(wr_addr), 64'd0);
        exp_q.push_back({1'b0, 32'h04030201});
        send(8'h01); send(8'h02);
        pulse_start();
        send(8'h03); send(8'h04);
        tick();
        chk("restart_count_after", 64'(img_count), 64'd1);

        // Reset after two bytes of a fill
        send(8'hEE); send(8'hDD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midfill_rst");
        chk("midfill_wr_data", 64'(wr_data), 64'd0);
        repeat (4) begin
            tick();
            chk("midfill_no_write", 64'(wr_en), 64'd0);
        end
        pulse_start();
        exp_q.push_back({1'b0, 32'h88776655});
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        tick();

        // Reset during the write cycle of the second image suppresses the write
        send(8'h99); send(8'h9A); send(8'h9B); send(8'h9C);
        rst = 1'b1;
        #1;
        chk("write_rst_wr_en", 64'(wr_en), 64'd0);
        tick();
        rst = 1'b0;
        chk_reset_vals("write_rst");
        repeat (3) tick();

        // Default parameters: one 256-byte image
        for (int i = 0; i < 256; i++) big_exp[8*i +: 8] = 8'(i);
        big_q.push_back(big_exp);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 256; i++) send_big(8'(i));
        repeat (5) tick();
        chk("big_write_count", 64'(big_writes), 64'd1);
        chk("big_img_count", 64'(b_img_count), 64'd1);
        chk("big_load_done", 64'(b_load_done), 64'd0);

        chk("small_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("big_queue_empty", 64'(big_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
